// File: rtl/controlador_display_mux_if.sv
// Bundle of display-controller data, control and pin signals.
// The master side drives the data/control inputs; the slave side is the controller itself.
interface controlador_display_mux_if #(
    parameter int unsigned DIGITOS = 4
);
    logic [4*DIGITOS-1:0] Dato;
    logic [DIGITOS-1:0]   Puntos;
    logic [DIGITOS-1:0]   Habilitar;
    logic                 Suprimir;
    logic                 Cargar;
    logic                 Ocupado;
    logic [6:0]           Segmentos;
    logic                 Punto;
    logic [DIGITOS-1:0]   Anodos;
    logic                 FinTrama;

    modport master (
        output Dato, Puntos, Habilitar, Suprimir, Cargar,
        input  Ocupado, Segmentos, Punto, Anodos, FinTrama
    );

    modport slave (
        input  Dato, Puntos, Habilitar, Suprimir, Cargar,
        output Ocupado, Segmentos, Punto, Anodos, FinTrama
    );
endinterface

// File: rtl/controlador_display_mux.sv
// Time-multiplexed common-anode seven-segment driver with double-buffered data,
// leading-zero suppression, per-digit enables and anti-ghosting blanking.
module controlador_display_mux #(
    parameter int unsigned DIGITOS = 4,
    parameter int unsigned DIV     = 50000,
    parameter int unsigned APAGADO = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    controlador_display_mux_if.slave    bus
);

    localparam int unsigned DW = 4 * DIGITOS;
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;

    logic [PW-1:0]      pre_q, pre_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [DW-1:0]      pend_dato_q, pend_dato_d;
    logic [DIGITOS-1:0] pend_pts_q, pend_pts_d;
    logic [DW-1:0]      sh_dato_q, sh_dato_d;
    logic [DIGITOS-1:0] sh_pts_q, sh_pts_d;
    logic               ocupado_q, ocupado_d;
    logic [6:0]         seg_q, seg_d;
    logic               punto_q, punto_d;
    logic [DIGITOS-1:0] anod_q, anod_d;
    logic               fin_q, fin_d;

    logic               fin_slot;
    logic               frontera;
    logic [DIGITOS-1:0] ceros_arriba;
    logic [3:0]         nibble;
    logic               encendido;
    logic               suprimido;

    function automatic logic [6:0] codigo_segmentos(input logic [3:0] n);
        logic [6:0] c;
        c = 7'h7F;
        case (n)
            4'h0: c = 7'b1000000;
            4'h1: c = 7'b1111001;
            4'h2: c = 7'b0100100;
            4'h3: c = 7'b0110000;
            4'h4: c = 7'b0011001;
            4'h5: c = 7'b0010010;
            4'h6: c = 7'b0000010;
            4'h7: c = 7'b1111000;
            4'h8: c = 7'b0000000;
            4'h9: c = 7'b0011000;
            4'hA: c = 7'b0001000;
            4'hB: c = 7'b0000011;
            4'hC: c = 7'b1000110;
            4'hD: c = 7'b0100001;
            4'hE: c = 7'b0000110;
            4'hF: c = 7'b0001110;
        endcase
        return c;
    endfunction

    // Prescaler and digit index; (idx=0, pre=0) is the frame boundary.
    always_comb begin
        fin_slot = (pre_q == PW'(DIV - 1));
        frontera = (pre_q == '0) && (idx_q == '0);
        pre_d    = fin_slot ? '0 : pre_q + 1'b1;
        idx_d    = idx_q;
        if (fin_slot) begin
            idx_d = (idx_q == IW'(DIGITOS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Boundary transfer uses the pending value from before this cycle's Cargar.
    always_comb begin
        pend_dato_d = pend_dato_q;
        pend_pts_d  = pend_pts_q;
        sh_dato_d   = sh_dato_q;
        sh_pts_d    = sh_pts_q;
        ocupado_d   = ocupado_q;
        if (frontera && ocupado_q) begin
            sh_dato_d = pend_dato_q;
            sh_pts_d  = pend_pts_q;
            ocupado_d = 1'b0;
        end
        if (bus.Cargar) begin
            pend_dato_d = bus.Dato;
            pend_pts_d  = bus.Puntos;
            ocupado_d   = 1'b1;
        end
    end

    // ceros_arriba[i]: shadow nibbles i..DIGITOS-1 are all zero.
    always_comb begin
        ceros_arriba = '0;
        for (int i = 0; i < int'(DIGITOS); i++) begin
            ceros_arriba[i] = ((sh_dato_d >> (4 * i)) == '0);
        end
    end

    // Output decode from the incoming shadow so new data lands with FinTrama.
    always_comb begin
        nibble    = sh_dato_d[{idx_q, 2'b00} +: 4];
        encendido = (pre_q >= PW'(APAGADO)) && bus.Habilitar[idx_q];
        suprimido = bus.Suprimir && (idx_q != '0) && ceros_arriba[idx_q];
        anod_d    = '1;
        seg_d     = 7'h7F;
        punto_d   = 1'b1;
        fin_d     = frontera;
        if (encendido) begin
            anod_d[idx_q] = 1'b0;
            if (!suprimido) begin
                seg_d = codigo_segmentos(nibble);
            end
            if (sh_pts_d[idx_q]) begin
                punto_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q       <= '0;
            idx_q       <= '0;
            pend_dato_q <= '0;
            pend_pts_q  <= '0;
            sh_dato_q   <= '0;
            sh_pts_q    <= '0;
            ocupado_q   <= 1'b0;
            seg_q       <= 7'h7F;
            punto_q     <= 1'b1;
            anod_q      <= '1;
            fin_q       <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            idx_q       <= idx_d;
            pend_dato_q <= pend_dato_d;
            pend_pts_q  <= pend_pts_d;
            sh_dato_q   <= sh_dato_d;
            sh_pts_q    <= sh_pts_d;
            ocupado_q   <= ocupado_d;
            seg_q       <= seg_d;
            punto_q     <= punto_d;
            anod_q      <= anod_d;
            fin_q       <= fin_d;
        end
    end

    assign bus.Ocupado   = ocupado_q;
    assign bus.Segmentos = seg_q;
    assign bus.Punto     = punto_q;
    assign bus.Anodos    = anod_q;
    assign bus.FinTrama  = fin_q;

endmodule

// File: doc/controlador_display_mux.md
# controlador_display_mux

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits. It holds a DIGITOS-nibble hex value in a double-buffered shadow register and scans one digit per refresh slot. Each slot drives the active-low segment pattern, the decimal point and a one-hot active-low anode. It adds three features on top of plain hex-to-segment decoding: leading-zero suppression, per-digit enables, and frame-aligned atomic updates. It sits between game/score logic and the board display pins.

## Interface
- DIGITOS, 4: number of digits, 1..8.
- DIV, 50000: clock cycles per digit slot, ≥ 2.
- APAGADO, 2: blanking cycles at the start of each slot (anti-ghosting), 0 ≤ APAGADO < DIV.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- Dato  in  4*DIGITOS  hex nibbles; digit i = Dato[4i+3:4i]; digit 0 is rightmost.
- Puntos  in  DIGITOS  decimal-point request per digit, active-high.
- Habilitar  in  DIGITOS  per-digit enable, sampled live; a disabled digit never lights.
- Suprimir  in  1  leading-zero suppression enable, sampled live.
- Cargar  in  1  single-cycle load strobe for Dato/Puntos.
- Ocupado  out  1  a load is pending a frame boundary.
- Segmentos  out  7  active-low segments; bit6..0 = g..a.
- Punto  out  1  active-low decimal point.
- Anodos  out  DIGITOS  active-low one-hot digit select.
- FinTrama  out  1  one-cycle pulse at each frame start.

## Operation
- Segment codes (Segmentos, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Blank = 1111111.
- Load path:
  - Cargar=1 copies Dato/Puntos into the pending register and sets Ocupado.
  - A repeat Cargar while Ocupado=1 overwrites the pending register; the latest value wins.
  - At a frame boundary with Ocupado=1, the pending register moves to the shadow and Ocupado clears.
  - The boundary transfers the pending value held before any Cargar in that same cycle. A Cargar in the boundary cycle is captured and Ocupado stays/becomes 1.
- Scan:
  - A prescaler counts 0..DIV-1 and advances the digit index idx at DIV-1.
  - idx counts 0..DIGITOS-1 and wraps to 0. A wrap is a frame boundary.
- Digit i is blank when Habilitar[i]=0, or when Suprimir=1, i≠0, and shadow nibbles i..DIGITOS-1 are all zero. Digit 0 is never zero-suppressed.
- Punto is low when digit i is selected, Habilitar[i]=1 and shadow Puntos[i]=1. This holds even if the digit is zero-suppressed.
- Anodos[idx] is low only when prescaler ≥ APAGADO and Habilitar[idx]=1; otherwise all anodes are high.
- While all anodes are high, Segmentos=7F and Punto=1.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Reset (asynchronous) forces, immediately:
  - Segmentos=7F, Punto=1, Anodos=all ones, FinTrama=0, Ocupado=0.
  - idx=0, prescaler=0, pending=0, shadow=0.
- Reset mid-frame aborts the scan and discards any pending load.
- After reset release, the first edge starts slot 0 of frame 0, and FinTrama pulses on that cycle.
- Slot length is exactly DIV cycles. Frame length is DIGITOS*DIV cycles. FinTrama pulses once per frame, in the first cycle of slot 0.
- New shadow data is visible starting with the first cycle of the frame whose FinTrama pulse clears Ocupado.
- Load latency from Cargar to display is at most DIGITOS*DIV+1 cycles.
- Habilitar and Suprimir changes take effect within one cycle (registered).

## Test plan
All scenarios use DIGITOS=4, DIV=4, APAGADO=1.
1. Reset, then idle. Required: Anodos repeats 1111,1110,1110,1110, 1111,1101×3, 1111,1011×3, 1111,0111×3. FinTrama pulses every 16 cycles. All digits show 1000000.
2. Cargar with Dato=16'h1234. Required: Ocupado=1 until the next FinTrama. Then digit0=0011001, digit1=0110000, digit2=0100100, digit3=1111001.
3. Suprimir=1 with Dato=16'h0050: digits 3 and 2 show 7F; digit1=0010010; digit0=1000000. With Dato=16'h0000, only digit0 lights, showing 1000000.
4. Habilitar=4'b1011, Puntos=4'b0010: the digit2 anode stays high for the whole slot. Punto is low only during the lit cycles of slot 1.
5. Cargar 16'hAAAA, then Cargar 16'hBBBB in the same frame, then Cargar 16'hCCCC exactly on the FinTrama cycle. Required: BBBB is displayed for one frame, then CCCC. AAAA is never displayed.
6. Assert reset asynchronously mid-slot 2 with a load pending. Required: outputs go to their reset values before the next edge, and Ocupado=0. After release, the display shows 0000.
